radix_digit_serializer: RTL and testbench

Sequential digit-extraction stage that converts one 8-bit byte into its radix-R digit string, most significant digit (MSD) first. It feeds the team's combinational div_8bit array divider, one division per clock: the working value goes to dividend_i and the radix to divisor_i. It consumes div_8bit's quotient_o and remainder_o. Digits are pushed into an internal stack, then streamed out under a valid/ready handshake to the display/trace formatting logic.

---
 rtl/radix_digit_serializer.sv | 179 +++++++++++++++++
 tb/tb_radix_digit_serializer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radix_digit_serializer.sv
// radix_digit_serializer
//   Converts one byte into its radix-R digit string (R = 2..15) and streams
//   the digits out most-significant first. One division per clock through a
//   combinational array divider; remainders are pushed onto a small stack and
//   popped in reverse order, which yields the MSD-first ordering.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   in_valid_i     byte_i / radix_i valid
//   in_ready_o     block can accept a new conversion (IDLE)
//   byte_i         value to convert
//   radix_i        conversion radix; values below 2 are rejected
//   digit_valid_o  digit_o holds a valid digit (EMIT)
//   digit_ready_i  downstream accepts the current digit
//   digit_o        digit value, 0..radix-1
//   digit_last_o   marks the least significant (final) digit
//   err_o          one-cycle pulse after an illegal radix is rejected
//   busy_o         conversion in progress (CALC or EMIT)

// div_8bit
//   Combinational restoring array divider: 8-bit dividend, 5-bit divisor.
//   A zero divisor returns an all-ones quotient; the serializer never
//   drives zero.
module div_8bit (
  input  logic [7:0] dividend_i,
  input  logic [4:0] divisor_i,
  output logic [7:0] quotient_o,
  output logic [4:0] remainder_o
);
  logic [8:0] part;

  always_comb begin
    part       = '0;
    quotient_o = '0;
    for (int i = 7; i >= 0; i--) begin
      // Partial remainder is always below the divisor (< 32), so the shift
      // never loses a significant bit.
      part = {part[7:0], dividend_i[i]};
      if (part >= {4'b0000, divisor_i}) begin
        part          = part - {4'b0000, divisor_i};
        quotient_o[i] = 1'b1;
      end
    end
    remainder_o = part[4:0];
  end
endmodule

module radix_digit_serializer #(
  parameter int MAX_DIGITS = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] byte_i,
  input  logic [3:0] radix_i,
  output logic       digit_valid_o,
  input  logic       digit_ready_i,
  output logic [3:0] digit_o,
  output logic       digit_last_o,
  output logic       err_o,
  output logic       busy_o
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int IW = $clog2(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      work_q, work_d;
  logic [3:0]      rad_q, rad_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      stack_q [MAX_DIGITS];
  logic [3:0]      stack_d [MAX_DIGITS];
  logic            err_q, err_d;

  logic [7:0]      quo;
  logic [4:0]      rem;
  logic [CW-1:0]   cnt_m1;
  logic [IW-1:0]   calc_idx;
  logic [IW-1:0]   emit_idx;
  logic            unused_rem_msb;

  div_8bit u_div (
    .dividend_i  (work_q),
    .divisor_i   ({1'b0, rad_q}),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // With radix <= 15 the remainder fits in four bits; the top bit is dead.
  assign unused_rem_msb = rem[4];

  assign cnt_m1   = cnt_q - CW'(1);
  assign calc_idx = cnt_q[IW-1:0];
  assign emit_idx = cnt_m1[IW-1:0];

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rad_d   = rad_q;
    cnt_d   = cnt_q;
    stack_d = stack_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (radix_i < 4'd2) begin
            err_d = 1'b1;
          end else begin
            work_d  = byte_i;
            rad_d   = radix_i;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        stack_d[calc_idx] = rem[3:0];
        cnt_d             = cnt_q + CW'(1);
        work_d            = quo;
        // The depth check can only fire if the quotient is already zero for
        // any legal radix; it keeps the stack index in range regardless.
        if ((quo == 8'd0) || (cnt_q == CW'(MAX_DIGITS - 1))) begin
          state_d = S_EMIT;
        end
      end

      S_EMIT: begin
        if (digit_ready_i) begin
          cnt_d = cnt_m1;
          if (cnt_q == CW'(1)) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      rad_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rad_q   <= rad_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int i = 0; i < MAX_DIGITS; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  // All outputs decode registered state only; digit_ready_i never reaches
  // digit_valid_o combinationally.
  assign in_ready_o    = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign digit_valid_o = (state_q == S_EMIT);
  assign digit_o       = (state_q == S_EMIT) ? stack_q[emit_idx] : 4'd0;
  assign digit_last_o  = (state_q == S_EMIT) && (cnt_q == CW'(1));
  assign err_o         = err_q;
endmodule

// File: tb/tb_radix_digit_serializer.sv
module tb_radix_digit_serializer;
  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid_i = 1'b0;
  logic [7:0] byte_i = '0;
  logic [3:0] radix_i = '0;
  logic       digit_ready_i = 1'b1;
  logic       in_ready_o;
  logic       digit_valid_o;
  logic [3:0] digit_o;
  logic       digit_last_o;
  logic       err_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  radix_digit_serializer #(.MAX_DIGITS(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .byte_i        (byte_i),
    .radix_i       (radix_i),
    .digit_valid_o (digit_valid_o),
    .digit_ready_i (digit_ready_i),
    .digit_o       (digit_o),
    .digit_last_o  (digit_last_o),
    .err_o         (err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // Present one request for a single clock edge; returns at the falling
  // edge right after the accepting edge.
  task automatic start_conv(input logic [7:0] b, input logic [3:0] r);
    @(negedge clk_i);
    in_valid_i = 1'b1;
    byte_i     = b;
    radix_i    = r;
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  // Count cycles until digit_valid_o rises (bounded at 20).
  task automatic measure_latency(output int k);
    k = 0;
    while (!digit_valid_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
  endtask

  // Record n consecutive digit cycles; digit i lands in nibble i.
  task automatic collect(input int n, output logic [31:0] digs,
                         output logic [7:0] lasts, output logic [7:0] valids);
    digs   = '0;
    lasts  = '0;
    valids = '0;
    for (int i = 0; i < n; i++) begin
      valids[i]      = digit_valid_o;
      lasts[i]       = digit_last_o;
      digs[4*i +: 4] = digit_o;
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({in_ready_o, digit_valid_o, digit_o, digit_last_o, err_o, busy_o} !== 9'b1_0_0000_0_0_0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b dig=%0d last=%b err=%b busy=%b, expected 1 0 0 0 0 0",
               in_ready_o, digit_valid_o, digit_o, digit_last_o, err_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: got rdy=%b busy=%b, expected 1 0", in_ready_o, busy_o);
    end
  endtask

  task automatic test_255_r10();
    int k;
    logic [31:0] d;
    logic [7:0] l, v;
    digit_ready_i = 1'b1;
    start_conv(8'd255, 4'd10);
    tests++;
    if (busy_o !== 1'b1 || in_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL calc_flags: got busy=%b rdy=%b, expected 1 0", busy_o, in_ready_o);
    end
    measure_latency(k);
    tests++;
    if (k !== 3) begin
      fails++;
      $display("FAIL 255_latency: got %0d, expected 3", k);
    end
    collect(3, d, l, v);
    tests++;
    if (d !== 32'h0000_0552 || l !== 8'b0000_0100 || v !== 8'b0000_0111) begin
      fails++;
      $display("FAIL 255_digits: got digs=%h last=%b vld=%b, expected 00000552 00000100 00000111", d, l, v);
    end
    tests++;
    if (in_ready_o !== 1'b1 || digit_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL 255_back_to_idle: got rdy=%b vld=%b, expected 1 0", in_ready_o, digit_valid_o);
    end
  endtask

  task automatic test_zero();
    int k;
    logic [31:0] d;
    logic [7:0] l, v;
    start_conv(8'd0, 4'd10);
    measure_latency(k);
    tests++;
    if (k !== 1) begin
      fails++;
      $display("FAIL zero_latency: got %0d, expected 1", k);
    end
    collect(1, d, l, v);
    tests++;
    if (d !== 32'h0 || l !== 8'b1 || v !== 8'b1) begin
      fails++;
      $display("FAIL zero_digit: got digs=%h last=%b vld=%b, expected 00000000 00000001 00000001", d, l, v);
    end
    tests++;
    if (digit_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL zero_single: got vld=%b rdy=%b, expected 0 1", digit_valid_o, in_ready_o);
    end
  endtask

  task automatic test_200_r2();
    int k;
    logic [31:0] d;
    logic [7:0] l, v;
    start_conv(8'd200, 4'd2);
    measure_latency(k);
    tests++;
    if (k !== 8) begin
      fails++;
      $display("FAIL 200_latency: got %0d, expected 8", k);
    end
    collect(8, d, l, v);
    // 200 = 1100_1000b, MSD first, digit i in nibble i
    tests++;
    if (d !== 32'h0001_0011 || l !== 8'h80 || v !== 8'hFF) begin
      fails++;
      $display("FAIL 200_digits: got digs=%h last=%b vld=%b, expected 00010011 10000000 11111111", d, l, v);
    end
    tests++;
    if (digit_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL 200_end: got vld=%b rdy=%b, expected 0 1", digit_valid_o, in_ready_o);
    end
  endtask

  task automatic test_backpressure();
    int k;
    int bad;
    logic [31:0] d;
    logic [7:0] l, v;
    digit_ready_i = 1'b0;
    start_conv(8'd171, 4'd15);
    measure_latency(k);
    tests++;
    if (k !== 2) begin
      fails++;
      $display("FAIL 171_latency: got %0d, expected 2", k);
    end
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      if (digit_o !== 4'd11 || digit_valid_o !== 1'b1 || digit_last_o !== 1'b0) bad++;
      @(negedge clk_i);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL 171_hold: %0d of 5 stalled cycles unstable, now dig=%0d vld=%b last=%b, expected 11 1 0",
               bad, digit_o, digit_valid_o, digit_last_o);
    end
    digit_ready_i = 1'b1;
    collect(2, d, l, v);
    tests++;
    if (d !== 32'h0000_006B || l !== 8'b10 || v !== 8'b11) begin
      fails++;
      $display("FAIL 171_digits: got digs=%h last=%b vld=%b, expected 0000006b 00000010 00000011", d, l, v);
    end
  endtask

  task automatic test_illegal_radix();
    int vseen;
    vseen = 0;
    @(negedge clk_i);
    in_valid_i = 1'b1;
    byte_i     = 8'd42;
    radix_i    = 4'd1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    tests++;
    if (err_o !== 1'b1 || in_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL radix1_err: got err=%b rdy=%b busy=%b, expected 1 1 0", err_o, in_ready_o, busy_o);
    end
    if (digit_valid_o) vseen++;
    @(negedge clk_i);
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL radix1_pulse_width: got err=%b, expected 0", err_o);
    end
    in_valid_i = 1'b1;
    radix_i    = 4'd0;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    tests++;
    if (err_o !== 1'b1 || in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL radix0_err: got err=%b rdy=%b, expected 1 1", err_o, in_ready_o);
    end
    for (int j = 0; j < 4; j++) begin
      if (digit_valid_o) vseen++;
      @(negedge clk_i);
    end
    tests++;
    if (vseen !== 0 || err_o !== 1'b0 || in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL illegal_no_digits: got vld_cycles=%0d err=%b rdy=%b, expected 0 0 1", vseen, err_o, in_ready_o);
    end
  endtask

  task automatic test_reset_abort();
    int k;
    logic [31:0] d;
    logic [7:0] l, v;
    start_conv(8'd123, 4'd10);
    measure_latency(k);
    tests++;
    if (k !== 3 || digit_o !== 4'd1) begin
      fails++;
      $display("FAIL 123_first: got lat=%0d dig=%0d, expected 3 1", k, digit_o);
    end
    @(negedge clk_i);
    tests++;
    if (digit_o !== 4'd2 || digit_valid_o !== 1'b1) begin
      fails++;
      $display("FAIL 123_second: got dig=%0d vld=%b, expected 2 1", digit_o, digit_valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({in_ready_o, digit_valid_o, digit_o, digit_last_o, err_o, busy_o} !== 9'b1_0_0000_0_0_0) begin
      fails++;
      $display("FAIL async_abort: got rdy=%b vld=%b dig=%0d last=%b err=%b busy=%b, expected 1 0 0 0 0 0",
               in_ready_o, digit_valid_o, digit_o, digit_last_o, err_o, busy_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (digit_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_idle: got vld=%b rdy=%b, expected 0 1", digit_valid_o, in_ready_o);
    end
    start_conv(8'd7, 4'd10);
    measure_latency(k);
    collect(1, d, l, v);
    tests++;
    if (k !== 1 || d !== 32'h7 || l !== 8'b1 || v !== 8'b1) begin
      fails++;
      $display("FAIL 7_after_reset: got lat=%0d digs=%h last=%b vld=%b, expected 1 00000007 00000001 00000001",
               k, d, l, v);
    end
    tests++;
    if (digit_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL 7_no_stale: got vld=%b rdy=%b, expected 0 1", digit_valid_o, in_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_255_r10();
    test_zero();
    test_200_r2();
    test_backpressure();
    test_illegal_radix();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
